// File: rtl/shell_pkg.sv
// Shared codes and default geometry for the multi-shell pool.
package shell_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_DOWN  = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_RIGHT = 2'b11
    } dir_e;

    typedef enum logic {
        SLOT_IDLE = 1'b0,
        SLOT_FLY  = 1'b1
    } slot_state_e;

    localparam int unsigned DEF_NUM_SHELLS = 4;
    localparam int unsigned DEF_COORD_W    = 5;
    localparam int unsigned DEF_GRID_W     = 25;
    localparam int unsigned DEF_GRID_H     = 13;
    localparam int unsigned DEF_CELL       = 20;
    localparam int unsigned DEF_ORIGIN     = 80;
    localparam int unsigned DEF_HALF       = 3;
    localparam int unsigned PIX_W          = 11;
    localparam int unsigned RGB_W          = 12;
    localparam logic [RGB_W-1:0] DEF_COLOR = 12'hFF0;

endpackage

// File: rtl/shell_pool_if.sv
// Fire-side handshake between tank/input logic (master) and the shell pool (slave).
interface shell_pool_if #(
    parameter int unsigned COORD_W = 5
);
    logic               fire_req;
    logic [1:0]         fire_dir;
    logic [COORD_W-1:0] fire_x;
    logic [COORD_W-1:0] fire_y;
    logic               fire_ack;
    logic               fire_drop;

    modport master (
        output fire_req, fire_dir, fire_x, fire_y,
        input  fire_ack, fire_drop
    );

    modport slave (
        input  fire_req, fire_dir, fire_x, fire_y,
        output fire_ack, fire_drop
    );
endinterface

// File: rtl/shell_slot.sv
// One shell slot: IDLE/FLY state, position and direction, edge exit, pixel hit flag.
module shell_slot
    import shell_pkg::*;
#(
    parameter int unsigned COORD_W = DEF_COORD_W,
    parameter int unsigned GRID_W  = DEF_GRID_W,
    parameter int unsigned GRID_H  = DEF_GRID_H,
    parameter int unsigned CELL    = DEF_CELL,
    parameter int unsigned ORIGIN  = DEF_ORIGIN,
    parameter int unsigned HALF    = DEF_HALF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               load,
    input  logic [COORD_W-1:0] load_x,
    input  logic [COORD_W-1:0] load_y,
    input  dir_e               load_dir,
    input  logic               tick,
    input  logic               kill,
    input  logic [PIX_W-1:0]   vga_x,
    input  logic [PIX_W-1:0]   vga_y,
    output logic               active,
    output logic [COORD_W-1:0] pos_x,
    output logic [COORD_W-1:0] pos_y,
    output logic               exit_pulse,
    output logic               hit_c
);

    localparam int unsigned HW = PIX_W + 1;

    slot_state_e state;
    dir_e        dir;
    logic        at_edge;
    logic [HW-1:0] cx, cy, sx, sy;

    assign active = (state == SLOT_FLY);

    // Next step would leave the grid in the latched direction.
    always_comb begin
        at_edge = 1'b0;
        case (dir)
            DIR_UP:    at_edge = (pos_y == '0);
            DIR_DOWN:  at_edge = (pos_y == COORD_W'(GRID_H - 1));
            DIR_LEFT:  at_edge = (pos_x == '0);
            DIR_RIGHT: at_edge = (pos_x == COORD_W'(GRID_W - 1));
            default:   at_edge = 1'b0;
        endcase
    end

    // Slot FSM: load on fire, step on tick, retire on kill (wins over tick) or edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= SLOT_IDLE;
            dir        <= DIR_UP;
            pos_x      <= '1;
            pos_y      <= '1;
            exit_pulse <= 1'b0;
        end else if (enable) begin
            exit_pulse <= 1'b0;
            case (state)
                SLOT_IDLE: begin
                    if (load) begin
                        state <= SLOT_FLY;
                        pos_x <= load_x;
                        pos_y <= load_y;
                        dir   <= load_dir;
                    end
                end
                SLOT_FLY: begin
                    if (kill) begin
                        state <= SLOT_IDLE;
                        pos_x <= '1;
                        pos_y <= '1;
                    end else if (tick) begin
                        if (at_edge) begin
                            state      <= SLOT_IDLE;
                            pos_x      <= '1;
                            pos_y      <= '1;
                            exit_pulse <= 1'b1;
                        end else begin
                            case (dir)
                                DIR_UP:    pos_y <= pos_y - COORD_W'(1);
                                DIR_DOWN:  pos_y <= pos_y + COORD_W'(1);
                                DIR_LEFT:  pos_x <= pos_x - COORD_W'(1);
                                DIR_RIGHT: pos_x <= pos_x + COORD_W'(1);
                                default:   pos_x <= pos_x;
                            endcase
                        end
                    end
                end
                default: state <= SLOT_IDLE;
            endcase
        end else begin
            exit_pulse <= 1'b0;
        end
    end

    // Pixel hit: |scan - centre| < HALF on both axes, kept unsigned by adding HALF.
    always_comb begin
        cx    = HW'(pos_x) * HW'(CELL) + HW'(ORIGIN);
        cy    = HW'(pos_y) * HW'(CELL) + HW'(ORIGIN);
        sx    = HW'(vga_x);
        sy    = HW'(vga_y);
        hit_c = active
              && (sx + HW'(HALF) > cx) && (sx < cx + HW'(HALF))
              && (sy + HW'(HALF) > cy) && (sy < cy + HW'(HALF));
    end

endmodule

// File: rtl/shell_pool.sv
// Pool of independent shell slots: fire arbitration, stepping, retirement, VGA render.
module shell_pool
    import shell_pkg::*;
#(
    parameter int unsigned       NUM_SHELLS = DEF_NUM_SHELLS,
    parameter int unsigned       COORD_W    = DEF_COORD_W,
    parameter int unsigned       GRID_W     = DEF_GRID_W,
    parameter int unsigned       GRID_H     = DEF_GRID_H,
    parameter int unsigned       CELL       = DEF_CELL,
    parameter int unsigned       ORIGIN     = DEF_ORIGIN,
    parameter int unsigned       HALF       = DEF_HALF,
    parameter logic [RGB_W-1:0]  COLOR      = DEF_COLOR
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic                          move_tick,
    shell_pool_if.slave                   fire,
    input  logic [NUM_SHELLS-1:0]         kill_mask,
    output logic [NUM_SHELLS-1:0]         shell_active,
    output logic [NUM_SHELLS*COORD_W-1:0] shell_x_flat,
    output logic [NUM_SHELLS*COORD_W-1:0] shell_y_flat,
    output logic [NUM_SHELLS-1:0]         exit_pulse,
    input  logic [PIX_W-1:0]              VGA_xpos,
    input  logic [PIX_W-1:0]              VGA_ypos,
    output logic [RGB_W-1:0]              VGA_data
);

    logic                  fire_ok;
    logic                  free_any;
    logic                  found;
    logic [NUM_SHELLS-1:0] load_vec;
    logic [NUM_SHELLS-1:0] hit_vec;
    logic                  ack_q;
    logic                  drop_q;

    assign fire.fire_ack  = ack_q;
    assign fire.fire_drop = drop_q;

    // Lowest-index slot idle at cycle start takes an in-bounds fire request.
    always_comb begin
        fire_ok  = enable && fire.fire_req
                 && (32'(fire.fire_x) < GRID_W) && (32'(fire.fire_y) < GRID_H);
        free_any = ~&shell_active;
        found    = 1'b0;
        load_vec = '0;
        for (int i = 0; i < NUM_SHELLS; i++) begin
            if (!found && !shell_active[i]) begin
                load_vec[i] = fire_ok;
                found       = 1'b1;
            end
        end
    end

    // Ack/drop pulses one cycle after the request.
    always_ff @(posedge clk) begin
        if (rst) begin
            ack_q  <= 1'b0;
            drop_q <= 1'b0;
        end else begin
            ack_q  <= fire_ok && free_any;
            drop_q <= enable && fire.fire_req && !(fire_ok && free_any);
        end
    end

    for (genvar i = 0; i < NUM_SHELLS; i++) begin : g_slot
        shell_slot #(
            .COORD_W (COORD_W),
            .GRID_W  (GRID_W),
            .GRID_H  (GRID_H),
            .CELL    (CELL),
            .ORIGIN  (ORIGIN),
            .HALF    (HALF)
        ) u_slot (
            .clk        (clk),
            .rst        (rst),
            .enable     (enable),
            .load       (load_vec[i]),
            .load_x     (fire.fire_x),
            .load_y     (fire.fire_y),
            .load_dir   (dir_e'(fire.fire_dir)),
            .tick       (move_tick),
            .kill       (kill_mask[i]),
            .vga_x      (VGA_xpos),
            .vga_y      (VGA_ypos),
            .active     (shell_active[i]),
            .pos_x      (shell_x_flat[i*COORD_W +: COORD_W]),
            .pos_y      (shell_y_flat[i*COORD_W +: COORD_W]),
            .exit_pulse (exit_pulse[i]),
            .hit_c      (hit_vec[i])
        );
    end

    // Registered pixel colour: any live shell covering the scan position.
    always_ff @(posedge clk) begin
        if (rst) begin
            VGA_data <= '0;
        end else begin
            VGA_data <= (enable && (|hit_vec)) ? COLOR : '0;
        end
    end

endmodule

// File: tb/tb_shell_pool.sv
// Directed bench for shell_pool with hand-computed expectations.
module tb_shell_pool;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        move_tick;
    logic [3:0]  kill_mask;
    logic [3:0]  shell_active;
    logic [19:0] shell_x_flat;
    logic [19:0] shell_y_flat;
    logic [3:0]  exit_pulse;
    logic [10:0] VGA_xpos;
    logic [10:0] VGA_ypos;
    logic [11:0] VGA_data;

    int total;
    int bad;

    shell_pool_if #(.COORD_W(5)) fif ();

    shell_pool dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .move_tick    (move_tick),
        .fire         (fif),
        .kill_mask    (kill_mask),
        .shell_active (shell_active),
        .shell_x_flat (shell_x_flat),
        .shell_y_flat (shell_y_flat),
        .exit_pulse   (exit_pulse),
        .VGA_xpos     (VGA_xpos),
        .VGA_ypos     (VGA_ypos),
        .VGA_data     (VGA_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_tick();
        move_tick = 1'b1;
        cyc();
        move_tick = 1'b0;
    endtask

    task automatic do_fire(input logic [4:0] x, input logic [4:0] y, input logic [1:0] d);
        fif.fire_req = 1'b1;
        fif.fire_x   = x;
        fif.fire_y   = y;
        fif.fire_dir = d;
        cyc();
        fif.fire_req = 1'b0;
    endtask

    initial begin
        total        = 0;
        bad          = 0;
        rst          = 1'b1;
        enable       = 1'b1;
        move_tick    = 1'b0;
        kill_mask    = 4'b0;
        VGA_xpos     = 11'd0;
        VGA_ypos     = 11'd0;
        fif.fire_req = 1'b0;
        fif.fire_x   = 5'd0;
        fif.fire_y   = 5'd0;
        fif.fire_dir = 2'b00;
        cyc();
        cyc();

        // Reset state
        chk("rst_active", 32'(shell_active), 32'h0);
        chk("rst_x", 32'(shell_x_flat), 32'hFFFFF);
        chk("rst_y", 32'(shell_y_flat), 32'hFFFFF);
        chk("rst_ack", 32'(fif.fire_ack), 32'h0);
        chk("rst_drop", 32'(fif.fire_drop), 32'h0);
        chk("rst_exit", 32'(exit_pulse), 32'h0);
        chk("rst_vga", 32'(VGA_data), 32'h0);
        rst = 1'b0;
        cyc();

        // Fire (3,5,up), step up to the top edge and out
        do_fire(5'd3, 5'd5, 2'b00);
        chk("t1_ack", 32'(fif.fire_ack), 32'h1);
        chk("t1_active", 32'(shell_active), 32'h1);
        chk("t1_x", 32'(shell_x_flat[4:0]), 32'd3);
        chk("t1_y", 32'(shell_y_flat[4:0]), 32'd5);
        cyc();
        chk("t1_ack_pulse", 32'(fif.fire_ack), 32'h0);
        do_tick();
        do_tick();
        chk("t1_y_after2", 32'(shell_y_flat[4:0]), 32'd3);
        do_tick();
        do_tick();
        do_tick();
        chk("t1_y_top", 32'(shell_y_flat[4:0]), 32'd0);
        chk("t1_no_exit_yet", 32'(exit_pulse), 32'h0);
        do_tick();
        chk("t1_exit", 32'(exit_pulse), 32'h1);
        chk("t1_y_ones", 32'(shell_y_flat[4:0]), 32'h1F);
        chk("t1_idle", 32'(shell_active), 32'h0);
        cyc();
        chk("t1_exit_pulse", 32'(exit_pulse), 32'h0);

        // Five back-to-back fires into four slots
        for (int i = 0; i < 5; i++) begin
            fif.fire_req = 1'b1;
            fif.fire_x   = 5'(i);
            fif.fire_y   = 5'd1;
            fif.fire_dir = 2'b01;
            cyc();
            if (i < 4) begin
                chk("t2_ack", 32'(fif.fire_ack), 32'h1);
                chk("t2_nodrop", 32'(fif.fire_drop), 32'h0);
            end else begin
                chk("t2_ack5", 32'(fif.fire_ack), 32'h0);
                chk("t2_drop5", 32'(fif.fire_drop), 32'h1);
            end
        end
        fif.fire_req = 1'b0;
        chk("t2_all_fly", 32'(shell_active), 32'hF);
        chk("t2_x", 32'(shell_x_flat), 32'({5'd3, 5'd2, 5'd1, 5'd0}));

        // Kill slot1 on the same cycle as a tick
        kill_mask = 4'b0010;
        do_tick();
        kill_mask = 4'b0000;
        chk("t3_active", 32'(shell_active), 32'hD);
        chk("t3_exit", 32'(exit_pulse), 32'h0);
        chk("t3_x", 32'(shell_x_flat), 32'({5'd3, 5'd2, 5'h1F, 5'd0}));
        chk("t3_y", 32'(shell_y_flat), 32'({5'd2, 5'd2, 5'h1F, 5'd2}));

        // Reset mid-flight with a fire request pending
        rst          = 1'b1;
        fif.fire_req = 1'b1;
        fif.fire_x   = 5'd0;
        fif.fire_y   = 5'd0;
        cyc();
        rst          = 1'b0;
        fif.fire_req = 1'b0;
        chk("t3_rst_active", 32'(shell_active), 32'h0);
        chk("t3_rst_ack", 32'(fif.fire_ack), 32'h0);
        chk("t3_rst_y", 32'(shell_y_flat), 32'hFFFFF);

        // Out-of-grid launch is dropped
        do_fire(5'd25, 5'd0, 2'b11);
        chk("t4_oob_drop", 32'(fif.fire_drop), 32'h1);
        chk("t4_oob_ack", 32'(fif.fire_ack), 32'h0);
        chk("t4_oob_active", 32'(shell_active), 32'h0);

        // Fire at right edge with coincident tick: no move, then exit next tick
        move_tick = 1'b1;
        do_fire(5'd24, 5'd0, 2'b11);
        move_tick = 1'b0;
        chk("t4_active", 32'(shell_active), 32'h1);
        chk("t4_x", 32'(shell_x_flat[4:0]), 32'd24);
        chk("t4_exit0", 32'(exit_pulse), 32'h0);
        do_tick();
        chk("t4_exit", 32'(exit_pulse), 32'h1);
        chk("t4_idle", 32'(shell_active), 32'h0);
        chk("t4_x_ones", 32'(shell_x_flat[4:0]), 32'h1F);

        // VGA hit test around the centre of cell (2,2) = pixel (120,120)
        do_fire(5'd2, 5'd2, 2'b00);
        VGA_xpos = 11'd118;
        VGA_ypos = 11'd118;
        cyc();
        chk("t5_hit", 32'(VGA_data), 32'hFF0);
        VGA_xpos = 11'd117;
        cyc();
        chk("t5_miss", 32'(VGA_data), 32'h000);
        VGA_xpos = 11'd122;
        VGA_ypos = 11'd122;
        cyc();
        chk("t5_hit_hi", 32'(VGA_data), 32'hFF0);
        VGA_ypos = 11'd123;
        cyc();
        chk("t5_miss_hi", 32'(VGA_data), 32'h000);

        // Disabled: ticks and fires ignored, VGA blanked
        VGA_xpos = 11'd118;
        VGA_ypos = 11'd118;
        enable   = 1'b0;
        do_tick();
        do_tick();
        do_tick();
        chk("t6_y_frozen", 32'(shell_y_flat[4:0]), 32'd2);
        chk("t6_active", 32'(shell_active), 32'h1);
        chk("t6_vga_off", 32'(VGA_data), 32'h0);
        do_fire(5'd1, 5'd1, 2'b00);
        chk("t6_no_ack", 32'(fif.fire_ack), 32'h0);
        chk("t6_no_drop", 32'(fif.fire_drop), 32'h0);
        enable = 1'b1;
        cyc();
        chk("t6_vga_back", 32'(VGA_data), 32'hFF0);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("t6_rst_active", 32'(shell_active), 32'h0);
        chk("t6_rst_x", 32'(shell_x_flat), 32'hFFFFF);
        chk("t6_rst_vga", 32'(VGA_data), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
